// File: rtl/core_seq_pkg.sv
// Shared constants, instruction-bus layout and FSM state encoding for the core sequencer.
package core_seq_pkg;

  localparam int unsigned ROW    = 8;
  localparam int unsigned COL    = 8;
  localparam int unsigned ADDR_W = 11;
  localparam int unsigned CNT_W  = 11;
  localparam int unsigned PROD_W = CNT_W + ADDR_W;
  localparam int unsigned INST_W = 34;

  localparam int unsigned ACC_BIT      = 33;
  localparam int unsigned CEN_PMEM_BIT = 32;
  localparam int unsigned WEN_PMEM_BIT = 31;
  localparam int unsigned A_PMEM_LSB   = 20;
  localparam int unsigned CEN_XMEM_BIT = 19;
  localparam int unsigned WEN_XMEM_BIT = 18;
  localparam int unsigned A_XMEM_LSB   = 7;
  localparam int unsigned OFIFO_RD_BIT = 6;
  localparam int unsigned IFIFO_WR_BIT = 5;
  localparam int unsigned IFIFO_RD_BIT = 4;
  localparam int unsigned L0_RD_BIT    = 3;
  localparam int unsigned L0_WR_BIT    = 2;
  localparam int unsigned EXECUTE_BIT  = 1;
  localparam int unsigned LOAD_BIT     = 0;

  typedef struct packed {
    logic              acc;
    logic              cen_pmem;
    logic              wen_pmem;
    logic [ADDR_W-1:0] a_pmem;
    logic              cen_xmem;
    logic              wen_xmem;
    logic [ADDR_W-1:0] a_xmem;
    logic              ofifo_rd;
    logic              ififo_wr;
    logic              ififo_rd;
    logic              l0_rd;
    logic              l0_wr;
    logic              execute;
    logic              load;
  } inst_t;

  localparam inst_t IDLE_INST = '{
    acc: 1'b0, cen_pmem: 1'b1, wen_pmem: 1'b1, a_pmem: '0,
    cen_xmem: 1'b1, wen_xmem: 1'b1, a_xmem: '0,
    ofifo_rd: 1'b0, ififo_wr: 1'b0, ififo_rd: 1'b0,
    l0_rd: 1'b0, l0_wr: 1'b0, execute: 1'b0, load: 1'b0
  };

  typedef struct packed {
    logic [CNT_W-1:0]  len;
    logic [CNT_W-1:0]  num_k;
    logic [ADDR_W-1:0] w_base;
    logic [ADDR_W-1:0] x_base;
    logic [ADDR_W-1:0] p_base;
    logic [ADDR_W-1:0] o_base;
    logic              act;
    logic              relu;
  } cfg_t;

  typedef enum logic [3:0] {
    S_IDLE, S_W_RD, S_K_LOAD, S_X_RD, S_EXEC,
    S_DRAIN, S_A_RST, S_A_RD, S_A_WR, S_FIN
  } state_e;

endpackage

// File: rtl/core_seq_addr_gen.sv
// SRAM address: base + outer*stride + inner, wrapping modulo 2^ADDR_W.
module core_seq_addr_gen
  import core_seq_pkg::*;
(
  input  logic [ADDR_W-1:0] base,
  input  logic [CNT_W-1:0]  outer,
  input  logic [CNT_W-1:0]  stride,
  input  logic [CNT_W-1:0]  inner,
  output logic [ADDR_W-1:0] addr_c
);

  always_comb begin
    addr_c = ADDR_W'(PROD_W'(base) + PROD_W'(outer) * PROD_W'(stride) + PROD_W'(inner));
  end

endmodule

// File: rtl/core_seq.sv
// Tiled matmul/conv instruction sequencer: per-kij weight/activation load, execute and
// OFIFO drain into psum SRAM, followed by one SFP accumulation pass over all outputs.
module core_seq
  import core_seq_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [CNT_W-1:0]  len,
  input  logic [CNT_W-1:0]  num_k,
  input  logic [ADDR_W-1:0] w_base,
  input  logic [ADDR_W-1:0] x_base,
  input  logic [ADDR_W-1:0] p_base,
  input  logic [ADDR_W-1:0] o_base,
  input  logic              act_cfg,
  input  logic              relu_cfg,
  input  logic              ofifo_valid,
  output logic [INST_W-1:0] inst,
  output logic              xw_mode,
  output logic              pmem_mode,
  output logic              sfp_reset,
  output logic              act_mode,
  output logic              relu_en,
  output logic              busy,
  output logic              done
);

  state_e            state_q, state_d;
  cfg_t              cfg_q, cfg_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  kij_q, kij_d;
  logic [CNT_W-1:0]  o_q, o_d;
  logic              rd_lag_q, rd_lag_d;
  logic              acc_lag_q, acc_lag_d;
  logic              pm_wr_q, pm_wr_d;
  logic [ADDR_W-1:0] pm_wa_q, pm_wa_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              sfp_reset_q, sfp_reset_d;
  logic              act_mode_q, act_mode_d;
  logic              relu_en_q, relu_en_d;

  inst_t             inst_c;
  logic              xw_mode_c, pmem_mode_c;

  logic [ADDR_W-1:0] xg_base, xg_addr, pg_base, pg_addr;
  logic [CNT_W-1:0]  xg_outer, xg_stride, pg_outer, pg_stride, pg_inner;

  // Address operand selection: xmem serves weights/activations, pmem serves drain/SFP.
  always_comb begin
    xg_base   = cfg_q.w_base;
    xg_outer  = kij_q;
    xg_stride = CNT_W'(COL);
    if (state_q == S_X_RD) begin
      xg_base   = cfg_q.x_base;
      xg_outer  = '0;
      xg_stride = '0;
    end
    pg_base   = cfg_q.p_base;
    pg_outer  = kij_q;
    pg_stride = cfg_q.len;
    pg_inner  = cnt_q;
    if (state_q == S_A_RD) begin
      pg_outer = cnt_q;
      pg_inner = o_q;
    end else if (state_q == S_A_WR) begin
      pg_base  = cfg_q.o_base;
      pg_outer = '0;
      pg_inner = o_q;
    end
  end

  core_seq_addr_gen u_xaddr (
    .base   (xg_base),
    .outer  (xg_outer),
    .stride (xg_stride),
    .inner  (cnt_q),
    .addr_c (xg_addr)
  );

  core_seq_addr_gen u_paddr (
    .base   (pg_base),
    .outer  (pg_outer),
    .stride (pg_stride),
    .inner  (pg_inner),
    .addr_c (pg_addr)
  );

  // Next-state and instruction decode; lag flops carry SRAM read latency into l0_wr/acc/pmem writes.
  always_comb begin
    state_d     = state_q;
    cfg_d       = cfg_q;
    cnt_d       = cnt_q;
    kij_d       = kij_q;
    o_d         = o_q;
    rd_lag_d    = 1'b0;
    acc_lag_d   = 1'b0;
    pm_wr_d     = 1'b0;
    pm_wa_d     = pm_wa_q;
    inst_c      = IDLE_INST;
    xw_mode_c   = 1'b0;
    pmem_mode_c = 1'b0;

    inst_c.l0_wr = rd_lag_q;
    inst_c.acc   = acc_lag_q;
    if (pm_wr_q) begin
      inst_c.cen_pmem = 1'b0;
      inst_c.wen_pmem = 1'b0;
      inst_c.a_pmem   = pm_wa_q;
    end

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          cfg_d = '{len: len, num_k: num_k, w_base: w_base, x_base: x_base,
                    p_base: p_base, o_base: o_base, act: act_cfg, relu: relu_cfg};
          cnt_d   = '0;
          kij_d   = '0;
          o_d     = '0;
          state_d = (len == '0 || num_k == '0) ? S_FIN : S_W_RD;
        end
      end
      S_W_RD: begin
        xw_mode_c = 1'b1;
        if (cnt_q < CNT_W'(COL)) begin
          inst_c.cen_xmem = 1'b0;
          inst_c.a_xmem   = xg_addr;
          rd_lag_d        = 1'b1;
          cnt_d           = cnt_q + CNT_W'(1);
        end else begin
          cnt_d   = '0;
          state_d = S_K_LOAD;
        end
      end
      S_K_LOAD: begin
        if (cnt_q < CNT_W'(ROW + COL)) begin
          inst_c.l0_rd = 1'b1;
          inst_c.load  = 1'b1;
          cnt_d        = cnt_q + CNT_W'(1);
        end else begin
          cnt_d   = '0;
          state_d = S_X_RD;
        end
      end
      S_X_RD: begin
        if (cnt_q < cfg_q.len) begin
          inst_c.cen_xmem = 1'b0;
          inst_c.a_xmem   = xg_addr;
          rd_lag_d        = 1'b1;
          cnt_d           = cnt_q + CNT_W'(1);
        end else begin
          cnt_d   = '0;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        inst_c.l0_rd   = 1'b1;
        inst_c.execute = 1'b1;
        if (cnt_q == cfg_q.len - CNT_W'(1)) begin
          cnt_d   = '0;
          state_d = S_DRAIN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DRAIN: begin
        if (cnt_q < cfg_q.len) begin
          if (ofifo_valid) begin
            inst_c.ofifo_rd = 1'b1;
            pm_wr_d         = 1'b1;
            pm_wa_d         = pg_addr;
            cnt_d           = cnt_q + CNT_W'(1);
          end
        end else begin
          cnt_d = '0;
          if (kij_q + CNT_W'(1) == cfg_q.num_k) begin
            o_d     = '0;
            state_d = S_A_RST;
          end else begin
            kij_d   = kij_q + CNT_W'(1);
            state_d = S_W_RD;
          end
        end
      end
      S_A_RST: begin
        cnt_d   = '0;
        state_d = S_A_RD;
      end
      S_A_RD: begin
        inst_c.cen_pmem = 1'b0;
        inst_c.a_pmem   = pg_addr;
        acc_lag_d       = 1'b1;
        if (cnt_q + CNT_W'(1) == cfg_q.num_k) begin
          cnt_d   = '0;
          state_d = S_A_WR;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_A_WR: begin
        pmem_mode_c = 1'b1;
        // sfp_out is registered in the core, so the write trails the last acc by two cycles
        if (cnt_q == CNT_W'(2)) begin
          inst_c.cen_pmem = 1'b0;
          inst_c.wen_pmem = 1'b0;
          inst_c.a_pmem   = pg_addr;
          cnt_d           = '0;
          if (o_q + CNT_W'(1) == cfg_q.len) begin
            state_d = S_FIN;
          end else begin
            o_d     = o_q + CNT_W'(1);
            state_d = S_A_RST;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_FIN);
    sfp_reset_d = (state_d == S_A_RST);
    act_mode_d  = (state_d != S_IDLE) ? cfg_d.act  : 1'b0;
    relu_en_d   = (state_d != S_IDLE) ? cfg_d.relu : 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cfg_q       <= '0;
      cnt_q       <= '0;
      kij_q       <= '0;
      o_q         <= '0;
      rd_lag_q    <= 1'b0;
      acc_lag_q   <= 1'b0;
      pm_wr_q     <= 1'b0;
      pm_wa_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      sfp_reset_q <= 1'b1;
      act_mode_q  <= 1'b0;
      relu_en_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cfg_q       <= cfg_d;
      cnt_q       <= cnt_d;
      kij_q       <= kij_d;
      o_q         <= o_d;
      rd_lag_q    <= rd_lag_d;
      acc_lag_q   <= acc_lag_d;
      pm_wr_q     <= pm_wr_d;
      pm_wa_q     <= pm_wa_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      sfp_reset_q <= sfp_reset_d;
      act_mode_q  <= act_mode_d;
      relu_en_q   <= relu_en_d;
    end
  end

  assign inst      = inst_c;
  assign xw_mode   = xw_mode_c;
  assign pmem_mode = pmem_mode_c;
  assign sfp_reset = sfp_reset_q;
  assign act_mode  = act_mode_q;
  assign relu_en   = relu_en_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_core_seq.sv
// Bench for core_seq: event-level reference model of a full run compared against a bus monitor.
`timescale 1ns/1ps
module tb_core_seq;
  import core_seq_pkg::*;

  logic              clk = 1'b0;
  logic              reset, start;
  logic [CNT_W-1:0]  len, num_k;
  logic [ADDR_W-1:0] w_base, x_base, p_base, o_base;
  logic              act_cfg, relu_cfg, ofifo_valid;
  logic [INST_W-1:0] inst;
  logic              xw_mode, pmem_mode, sfp_reset, act_mode, relu_en, busy, done;

  always #5 clk = ~clk;

  core_seq dut (
    .clk(clk), .reset(reset), .start(start), .len(len), .num_k(num_k),
    .w_base(w_base), .x_base(x_base), .p_base(p_base), .o_base(o_base),
    .act_cfg(act_cfg), .relu_cfg(relu_cfg), .ofifo_valid(ofifo_valid),
    .inst(inst), .xw_mode(xw_mode), .pmem_mode(pmem_mode), .sfp_reset(sfp_reset),
    .act_mode(act_mode), .relu_en(relu_en), .busy(busy), .done(done)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Bus monitor: records SRAM/core events and timing-rule violations.
  logic              mon_en = 1'b0;
  logic              mon_clr = 1'b0;
  logic              exp_act, exp_relu;
  logic [ADDR_W:0]   obs_xrd[$];
  logic [ADDR_W:0]   obs_pwr[$];
  logic [ADDR_W-1:0] obs_prd[$];
  int n_load, n_exec, n_l0wr, n_acc, n_sfp, n_done, proto_err, act_err;
  logic prev_xrd, prev_prd, prev_ofrd, acc_d1, acc_d2;

  always @(negedge clk) begin
    logic xrd, prd, pwr;
    if (mon_clr) begin
      obs_xrd.delete(); obs_pwr.delete(); obs_prd.delete();
      n_load = 0; n_exec = 0; n_l0wr = 0; n_acc = 0; n_sfp = 0; n_done = 0;
      proto_err = 0; act_err = 0;
      prev_xrd = 1'b0; prev_prd = 1'b0; prev_ofrd = 1'b0; acc_d1 = 1'b0; acc_d2 = 1'b0;
    end else if (mon_en) begin
      xrd = !inst[CEN_XMEM_BIT];
      prd = !inst[CEN_PMEM_BIT] && inst[WEN_PMEM_BIT];
      pwr = !inst[CEN_PMEM_BIT] && !inst[WEN_PMEM_BIT];
      if (xrd) obs_xrd.push_back({xw_mode, inst[A_XMEM_LSB +: ADDR_W]});
      if (prd) obs_prd.push_back(inst[A_PMEM_LSB +: ADDR_W]);
      if (pwr) obs_pwr.push_back({pmem_mode, inst[A_PMEM_LSB +: ADDR_W]});
      if (inst[WEN_XMEM_BIT] !== 1'b1 || inst[IFIFO_WR_BIT] || inst[IFIFO_RD_BIT]) proto_err++;
      if (inst[L0_WR_BIT] !== prev_xrd) proto_err++;
      if (inst[ACC_BIT] !== prev_prd) proto_err++;
      if (inst[OFIFO_RD_BIT] && !ofifo_valid) proto_err++;
      if (prev_ofrd !== (pwr && !pmem_mode)) proto_err++;
      if (pwr && pmem_mode && !(acc_d2 && !acc_d1)) proto_err++;
      if ((inst[LOAD_BIT] || inst[EXECUTE_BIT]) && !inst[L0_RD_BIT]) proto_err++;
      if (busy && (act_mode !== exp_act || relu_en !== exp_relu)) act_err++;
      if (inst[LOAD_BIT]) n_load++;
      if (inst[EXECUTE_BIT]) n_exec++;
      if (inst[L0_WR_BIT]) n_l0wr++;
      if (inst[ACC_BIT]) n_acc++;
      if (sfp_reset) n_sfp++;
      if (done) n_done++;
      prev_xrd  = xrd;
      prev_prd  = prd;
      prev_ofrd = inst[OFIFO_RD_BIT];
      acc_d2    = acc_d1;
      acc_d1    = inst[ACC_BIT];
    end
  end

  // One full run: build expected event lists from the loop nest, run the DUT, compare.
  // vmode 0: random ofifo_valid; 1: ofifo_valid low for the first 45 cycles.
  task automatic run(input int l, input int nk, input int wb, input int xb, input int pb,
                     input int ob, input int vmode, input int restart_at);
    logic [ADDR_W:0]   ex_xrd[$];
    logic [ADDR_W:0]   ex_pwr[$];
    logic [ADDR_W-1:0] ex_prd[$];
    int amod, eff, cyc;
    amod = 1 << ADDR_W;
    eff  = (l > 0 && nk > 0) ? 1 : 0;
    if (eff == 1) begin
      for (int k = 0; k < nk; k++) begin
        for (int c = 0; c < int'(COL); c++) ex_xrd.push_back({1'b1, ADDR_W'((wb + k * int'(COL) + c) % amod)});
        for (int i = 0; i < l; i++) ex_xrd.push_back({1'b0, ADDR_W'((xb + i) % amod)});
        for (int j = 0; j < l; j++) ex_pwr.push_back({1'b0, ADDR_W'((pb + k * l + j) % amod)});
      end
      for (int o = 0; o < l; o++) begin
        for (int k = 0; k < nk; k++) ex_prd.push_back(ADDR_W'((pb + k * l + o) % amod));
        ex_pwr.push_back({1'b1, ADDR_W'((ob + o) % amod)});
      end
    end
    len = CNT_W'(l); num_k = CNT_W'(nk);
    w_base = ADDR_W'(wb); x_base = ADDR_W'(xb); p_base = ADDR_W'(pb); o_base = ADDR_W'(ob);
    act_cfg = 1'($urandom_range(0, 1)); relu_cfg = 1'($urandom_range(0, 1));
    exp_act = act_cfg; exp_relu = relu_cfg;
    mon_clr = 1'b1;
    @(negedge clk);
    #1 mon_clr = 1'b0; mon_en = 1'b1;
    @(posedge clk); #1 start = 1'b1;
    cyc = 0;
    while (n_done == 0 && cyc < 3000) begin
      @(posedge clk); #1;
      start = (restart_at > 0 && cyc == restart_at);
      if (start) begin
        len = CNT_W'($urandom_range(1, 9)); num_k = CNT_W'($urandom_range(1, 4));
        p_base = ADDR_W'($urandom); act_cfg = ~act_cfg; relu_cfg = ~relu_cfg;
      end
      ofifo_valid = (vmode == 1) ? (cyc >= 45) : ($urandom_range(0, 3) != 0);
      cyc++;
    end
    repeat (4) @(negedge clk);
    mon_en = 1'b0;
    check("done_pulses", 64'(n_done), 64'd1);
    check("busy_after", 64'(busy), 64'd0);
    check("xrd_count", 64'(obs_xrd.size()), 64'(ex_xrd.size()));
    foreach (ex_xrd[i]) if (i < obs_xrd.size()) check("xrd", 64'(obs_xrd[i]), 64'(ex_xrd[i]));
    check("pwr_count", 64'(obs_pwr.size()), 64'(ex_pwr.size()));
    foreach (ex_pwr[i]) if (i < obs_pwr.size()) check("pwr", 64'(obs_pwr[i]), 64'(ex_pwr[i]));
    check("prd_count", 64'(obs_prd.size()), 64'(ex_prd.size()));
    foreach (ex_prd[i]) if (i < obs_prd.size()) check("prd", 64'(obs_prd[i]), 64'(ex_prd[i]));
    check("load_cycles", 64'(n_load), 64'(eff * nk * int'(ROW + COL)));
    check("exec_cycles", 64'(n_exec), 64'(eff * nk * l));
    check("l0_wr_pulses", 64'(n_l0wr), 64'(eff * nk * (int'(COL) + l)));
    check("acc_pulses", 64'(n_acc), 64'(eff * nk * l));
    check("sfp_resets", 64'(n_sfp), 64'(eff * l));
    check("timing_rules", 64'(proto_err), 64'd0);
    check("act_relu_hold", 64'(act_err), 64'd0);
  endtask

  initial begin
    logic [INST_W-1:0] idle_exp;
    int bad, cyc;
    idle_exp = '0;
    idle_exp[CEN_PMEM_BIT] = 1'b1; idle_exp[WEN_PMEM_BIT] = 1'b1;
    idle_exp[CEN_XMEM_BIT] = 1'b1; idle_exp[WEN_XMEM_BIT] = 1'b1;
    reset = 1'b1; start = 1'b0; ofifo_valid = 1'b0; act_cfg = 1'b1; relu_cfg = 1'b1;
    len = '0; num_k = '0; w_base = '0; x_base = '0; p_base = '0; o_base = '0;
    exp_act = 1'b0; exp_relu = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_inst", 64'(inst), 64'(idle_exp));
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_sfp_reset", 64'(sfp_reset), 64'd1);
    check("rst_modes", 64'({xw_mode, pmem_mode, act_mode, relu_en}), 64'd0);
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("idle_sfp_reset", 64'(sfp_reset), 64'd0);
    check("idle_inst", 64'(inst), 64'(idle_exp));

    run(4, 1, 'h10, 'h40, 'h300, 'h380, 0, 0);
    run(3, 2, 'h20, 'h60, 'h100, 'h200, 0, 0);
    run(4, 1, 'h00, 'h08, 'h180, 'h280, 1, 0);
    run(4, 1, 'h7F8, 'h7FC, 'h7FE, 'h7FF, 0, 0);
    run(3, 2, 'h30, 'h50, 'h120, 'h220, 0, 20);
    run(2, 0, 'h30, 'h50, 'h120, 'h220, 0, 0);

    // len = 0: done in the cycle right after the accepting edge, no SRAM activity.
    len = '0; num_k = CNT_W'(3);
    mon_clr = 1'b1;
    @(negedge clk);
    #1 mon_clr = 1'b0; mon_en = 1'b1;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    check("len0_done", 64'(done), 64'd1);
    @(negedge clk);
    check("len0_done_drop", 64'(done), 64'd0);
    check("len0_busy_drop", 64'(busy), 64'd0);
    mon_en = 1'b0;
    check("len0_no_activity", 64'(obs_xrd.size() + obs_pwr.size() + obs_prd.size() + n_load), 64'd0);

    for (int r = 0; r < 6; r++)
      run($urandom_range(1, 6), $urandom_range(1, 3), $urandom, $urandom, $urandom, $urandom, 0, 0);

    // Reset in the middle of EXEC abandons the run.
    len = CNT_W'(4); num_k = CNT_W'(1);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    cyc = 0;
    while (!inst[EXECUTE_BIT] && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check("reached_exec", 64'(inst[EXECUTE_BIT]), 64'd1);
    #1 reset = 1'b1;
    #1;
    check("midrst_inst", 64'(inst), 64'(idle_exp));
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_sfp_reset", 64'(sfp_reset), 64'd1);
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk);
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done || busy || sfp_reset || inst !== idle_exp) bad++;
    end
    check("post_reset_idle", 64'(bad), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
